ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-read-port / single-write-port 4096×16 program RAM between the j1 CPU and a secondary DMA/loader master. It sits between the CPU's `mem_*` ports and the RAM and arbitrates the read and write channels independently every cycle. The CPU has default priority, and a bounded-wait counter guarantees the DMA progress. Read data is returned one cycle after grant and tagged to its owner.

---
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a 1R/1W program RAM. Read and write
// channels arbitrate independently: CPU priority with a bounded DMA wait.
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_rd_req,
  input  logic [ADDR_W-1:0] c_rd_addr,
  output logic              c_rd_gnt,
  output logic              c_rd_valid,
  output logic [DATA_W-1:0] c_rd_data,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_gnt,
  output logic              d_rd_valid,
  output logic [DATA_W-1:0] d_rd_data,
  input  logic              c_wr_req,
  input  logic [ADDR_W-1:0] c_wr_addr,
  input  logic [DATA_W-1:0] c_wr_data,
  output logic              c_wr_gnt,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_gnt,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [15:0]       conflict_count
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  logic [7:0]  r_rd_wait;
  logic [7:0]  r_wr_wait;
  owner_t      r_rd_owner;
  logic [15:0] r_conflict;

  // Requests are masked while reset is high so no grant can leak out.
  logic w_c_rd_act, w_d_rd_act, w_c_wr_act, w_d_wr_act;
  logic w_rd_dma_win, w_wr_dma_win;
  logic w_rd_conflict, w_wr_conflict;

  assign w_c_rd_act = c_rd_req & ~reset;
  assign w_d_rd_act = d_rd_req & ~reset;
  assign w_c_wr_act = c_wr_req & ~reset;
  assign w_d_wr_act = d_wr_req & ~reset;

  assign w_rd_conflict = w_c_rd_act & w_d_rd_act;
  assign w_wr_conflict = w_c_wr_act & w_d_wr_act;

  assign w_rd_dma_win = w_d_rd_act & (~w_c_rd_act | (r_rd_wait == LP_MAX_WAIT));
  assign w_wr_dma_win = w_d_wr_act & (~w_c_wr_act | (r_wr_wait == LP_MAX_WAIT));

  assign d_rd_gnt = w_rd_dma_win;
  assign c_rd_gnt = w_c_rd_act & ~w_rd_dma_win;
  assign d_wr_gnt = w_wr_dma_win;
  assign c_wr_gnt = w_c_wr_act & ~w_wr_dma_win;

  assign mem_read_enable  = c_rd_gnt | d_rd_gnt;
  assign mem_read_address = d_rd_gnt ? d_rd_addr :
                            c_rd_gnt ? c_rd_addr : '0;

  assign mem_write_enable  = c_wr_gnt | d_wr_gnt;
  assign mem_write_address = d_wr_gnt ? d_wr_addr :
                             c_wr_gnt ? c_wr_addr : '0;
  assign mem_write_data    = d_wr_gnt ? d_wr_data :
                             c_wr_gnt ? c_wr_data : '0;

  // The RAM's registered read lands while the owner register holds the winner.
  assign c_rd_valid = (r_rd_owner == OWN_CPU) & ~reset;
  assign d_rd_valid = (r_rd_owner == OWN_DMA) & ~reset;
  assign c_rd_data  = mem_read_data;
  assign d_rd_data  = mem_read_data;

  assign conflict_count = r_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_wait  <= '0;
      r_wr_wait  <= '0;
      r_rd_owner <= OWN_NONE;
      r_conflict <= '0;
    end else begin
      if (w_d_rd_act & ~d_rd_gnt)
        r_rd_wait <= (r_rd_wait == LP_MAX_WAIT) ? r_rd_wait : r_rd_wait + 8'd1;
      else
        r_rd_wait <= '0;

      if (w_d_wr_act & ~d_wr_gnt)
        r_wr_wait <= (r_wr_wait == LP_MAX_WAIT) ? r_wr_wait : r_wr_wait + 8'd1;
      else
        r_wr_wait <= '0;

      if (d_rd_gnt)
        r_rd_owner <= OWN_DMA;
      else if (c_rd_gnt)
        r_rd_owner <= OWN_CPU;
      else
        r_rd_owner <= OWN_NONE;

      if ((w_rd_conflict | w_wr_conflict) && (r_conflict != 16'hFFFF))
        r_conflict <= r_conflict + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle reference model with compare
// process, plus directed vectors with literal expectations.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_rd_req, d_rd_req, c_wr_req, d_wr_req;
  logic [AW-1:0] c_rd_addr, d_rd_addr, c_wr_addr, d_wr_addr;
  logic [DW-1:0] c_wr_data, d_wr_data;
  logic          c_rd_gnt, d_rd_gnt, c_wr_gnt, d_wr_gnt;
  logic          c_rd_valid, d_rd_valid;
  logic [DW-1:0] c_rd_data, d_rd_data;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data, mem_write_data;
  logic [15:0]   conflict_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .c_rd_req(c_rd_req), .c_rd_addr(c_rd_addr), .c_rd_gnt(c_rd_gnt),
    .c_rd_valid(c_rd_valid), .c_rd_data(c_rd_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_gnt(d_rd_gnt),
    .d_rd_valid(d_rd_valid), .d_rd_data(d_rd_data),
    .c_wr_req(c_wr_req), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data), .c_wr_gnt(c_wr_gnt),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_gnt(d_wr_gnt),
    .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .conflict_count(conflict_count)
  );

  // Environment RAM: 4096x16, registered read, read-first on collisions.
  logic [DW-1:0] ram [4096];
  always @(posedge clk) begin
    if (mem_read_enable)  mem_read_data <= ram[mem_read_address[11:0]];
    if (mem_write_enable) ram[mem_write_address[11:0]] <= mem_write_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: separate memory copy, per-channel wait counts, owner of
  // the pending read and the data it must return.
  logic [DW-1:0] m_mem [4096];
  int            m_rd_wait = 0, m_wr_wait = 0, m_owner = 0, m_cc = 0;
  logic [DW-1:0] m_rdata = '0;

  always @(negedge clk) begin
    bit crd, drd, cwr, dwr, e_crd, e_drd, e_cwr, e_dwr;
    logic [AW-1:0] e_raddr, e_waddr;
    logic [DW-1:0] e_wdata;
    crd = !reset && c_rd_req;
    drd = !reset && d_rd_req;
    cwr = !reset && c_wr_req;
    dwr = !reset && d_wr_req;
    e_drd = drd && (!crd || m_rd_wait == MW);
    e_crd = crd && !e_drd;
    e_dwr = dwr && (!cwr || m_wr_wait == MW);
    e_cwr = cwr && !e_dwr;
    e_raddr = e_drd ? d_rd_addr : (e_crd ? c_rd_addr : '0);
    e_waddr = e_dwr ? d_wr_addr : (e_cwr ? c_wr_addr : '0);
    e_wdata = e_dwr ? d_wr_data : (e_cwr ? c_wr_data : '0);

    chk("c_rd_gnt", 32'(c_rd_gnt), 32'(e_crd));
    chk("d_rd_gnt", 32'(d_rd_gnt), 32'(e_drd));
    chk("c_wr_gnt", 32'(c_wr_gnt), 32'(e_cwr));
    chk("d_wr_gnt", 32'(d_wr_gnt), 32'(e_dwr));
    chk("mem_read_enable", 32'(mem_read_enable), 32'(e_crd || e_drd));
    chk("mem_read_address", 32'(mem_read_address), 32'(e_raddr));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(e_cwr || e_dwr));
    chk("mem_write_address", 32'(mem_write_address), 32'(e_waddr));
    chk("mem_write_data", 32'(mem_write_data), 32'(e_wdata));
    chk("c_rd_valid", 32'(c_rd_valid), 32'(!reset && m_owner == 1));
    chk("d_rd_valid", 32'(d_rd_valid), 32'(!reset && m_owner == 2));
    if (!reset && m_owner == 1) chk("c_rd_data", 32'(c_rd_data), 32'(m_rdata));
    if (!reset && m_owner == 2) chk("d_rd_data", 32'(d_rd_data), 32'(m_rdata));
    chk("conflict_count", 32'(conflict_count), 32'(m_cc));

    if (reset) begin
      m_rd_wait = 0; m_wr_wait = 0; m_owner = 0; m_cc = 0;
    end else begin
      m_rd_wait = (drd && !e_drd) ? ((m_rd_wait < MW) ? m_rd_wait + 1 : MW) : 0;
      m_wr_wait = (dwr && !e_dwr) ? ((m_wr_wait < MW) ? m_wr_wait + 1 : MW) : 0;
      if ((crd && drd) || (cwr && dwr)) m_cc = (m_cc < 65535) ? m_cc + 1 : 65535;
      m_owner = e_drd ? 2 : (e_crd ? 1 : 0);
      if (e_crd || e_drd) m_rdata = m_mem[e_raddr[11:0]];
      if (e_cwr || e_dwr) m_mem[e_waddr[11:0]] = e_wdata;
    end
  end

  task automatic idle();
    c_rd_req = 0; d_rd_req = 0; c_wr_req = 0; d_wr_req = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    ram[5] = 16'hABCD;
    m_mem[5] = 16'hABCD;
    mem_read_data = '0;
    reset = 1;
    c_rd_req = 1; d_rd_req = 1; c_wr_req = 1; d_wr_req = 1;
    c_rd_addr = 16'd1; d_rd_addr = 16'd2; c_wr_addr = 16'd3; d_wr_addr = 16'd4;
    c_wr_data = 16'h5555; d_wr_data = 16'h6666;

    $display("[TB] reset with all requests high");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnts", {28'd0, c_rd_gnt, d_rd_gnt, c_wr_gnt, d_wr_gnt}, 32'd0);
      chk("rst_valids", {30'd0, c_rd_valid, d_rd_valid}, 32'd0);
      chk("rst_enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
      chk("rst_conflict", 32'(conflict_count), 32'd0);
      next_cycle();
    end

    $display("[TB] continuous dual read, MAX_WAIT=%0d", MW);
    reset = 0; c_wr_req = 0; d_wr_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair_c_gnt", 32'(c_rd_gnt), (i == 4 || i == 9) ? 32'd0 : 32'd1);
      chk("fair_d_gnt", 32'(d_rd_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("fair_conflicts", 32'(conflict_count), 32'd10);
    next_cycle();

    $display("[TB] CPU read of 0x0005");
    c_rd_req = 1; c_rd_addr = 16'h0005;
    @(negedge clk);
    chk("cpu_rd_gnt", 32'(c_rd_gnt), 32'd1);
    chk("cpu_rd_dvalid0", 32'(d_rd_valid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("cpu_rd_valid", 32'(c_rd_valid), 32'd1);
    chk("cpu_rd_data", 32'(c_rd_data), 32'h0000ABCD);
    chk("cpu_rd_dvalid1", 32'(d_rd_valid), 32'd0);
    next_cycle();

    $display("[TB] CPU write 0x1234 @0x0010 with DMA read same address");
    c_wr_req = 1; c_wr_addr = 16'h0010; c_wr_data = 16'h1234;
    d_rd_req = 1; d_rd_addr = 16'h0010;
    @(negedge clk);
    chk("raw_c_wr_gnt", 32'(c_wr_gnt), 32'd1);
    chk("raw_d_rd_gnt", 32'(d_rd_gnt), 32'd1);
    next_cycle();
    c_wr_req = 0;
    @(negedge clk);
    chk("raw_old_valid", 32'(d_rd_valid), 32'd1);
    chk("raw_old_data", 32'(d_rd_data), 32'h0);
    chk("raw_reread_gnt", 32'(d_rd_gnt), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("raw_new_data", 32'(d_rd_data), 32'h1234);
    next_cycle();

    $display("[TB] both write 0x0020 (CPU 0x1111, DMA 0x2222)");
    c_wr_req = 1; c_wr_addr = 16'h0020; c_wr_data = 16'h1111;
    d_wr_req = 1; d_wr_addr = 16'h0020; d_wr_data = 16'h2222;
    @(negedge clk);
    chk("waw_c_gnt", 32'(c_wr_gnt), 32'd1);
    chk("waw_d_wait", 32'(d_wr_gnt), 32'd0);
    next_cycle();
    c_wr_req = 0;
    @(negedge clk);
    chk("waw_d_gnt", 32'(d_wr_gnt), 32'd1);
    chk("waw_d_data", 32'(mem_write_data), 32'h2222);
    next_cycle();
    idle();
    c_rd_req = 1; c_rd_addr = 16'h0020;
    @(negedge clk);
    next_cycle();
    idle();
    @(negedge clk);
    chk("waw_final", 32'(c_rd_data), 32'h2222);
    next_cycle();

    $display("[TB] DMA drops request mid-wait, wait count restarts");
    c_rd_req = 1; c_rd_addr = 16'h0001; d_rd_addr = 16'h0005;
    for (int i = 0; i < 10; i++) begin
      d_rd_req = (i != 3);
      @(negedge clk);
      chk("drop_d_gnt", 32'(d_rd_gnt), (i == 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle();

    $display("[TB] DMA read then reset next cycle");
    d_rd_req = 1; d_rd_addr = 16'h0005;
    @(negedge clk);
    chk("rst_dma_gnt", 32'(d_rd_gnt), 32'd1);
    next_cycle();
    idle();
    reset = 1;
    @(negedge clk);
    chk("rst_dma_valid", 32'(d_rd_valid), 32'd0);
    next_cycle();
    reset = 0;
    c_rd_req = 1; c_rd_addr = 16'h0005;
    @(negedge clk);
    chk("post_rst_gnt", 32'(c_rd_gnt), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("post_rst_valid", 32'(c_rd_valid), 32'd1);
    chk("post_rst_data", 32'(c_rd_data), 32'h0000ABCD);
    chk("post_rst_dvalid", 32'(d_rd_valid), 32'd0);
    next_cycle();

    $display("[TB] mixed traffic, 300 cycles");
    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      c_rd_req = ($urandom_range(0, 3) != 0);
      d_rd_req = ($urandom_range(0, 2) != 0);
      c_wr_req = ($urandom_range(0, 2) != 0);
      d_wr_req = ($urandom_range(0, 2) != 0);
      c_rd_addr = 16'(16'h0040 + $urandom_range(0, 7));
      d_rd_addr = 16'(16'h0040 + $urandom_range(0, 7));
      c_wr_addr = 16'(16'h0040 + $urandom_range(0, 7));
      d_wr_addr = 16'(16'h0040 + $urandom_range(0, 7));
      c_wr_data = 16'($urandom);
      d_wr_data = 16'($urandom);
      next_cycle();
    end
    reset = 0;
    idle();
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
